// File: rtl/bcd_jk_down_counter_pkg.sv
// Shared BCD constants and digit helpers for
// the JK-based down-counter.
package bcd_jk_down_counter_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_t;

    localparam bcd_t BCD_MAX  = 4'd9;
    localparam bcd_t BCD_ZERO = 4'd0;

    function automatic bcd_t bcd_clamp(
        input bcd_t d
    );
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

    // Zero borrows around to nine.
    function automatic bcd_t bcd_dec(
        input bcd_t d
    );
        return (d == BCD_ZERO) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/bcd_jk_down_digit.sv
// One BCD decade: four JK flops plus
// load/clamp/decrement next-state logic.
module bcd_jk_down_digit
    import bcd_jk_down_counter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       dec_in,
    input  logic       load,
    input  logic [3:0] load_digit,
    output logic [3:0] digit,
    output logic       is_zero
);

    bcd_t nxt;

    always_comb begin
        nxt = digit;
        if (load) begin
            nxt = bcd_clamp(load_digit);
        end else if (dec_in) begin
            nxt = bcd_dec(digit);
        end
    end

    // J sets a bit that must rise, K clears one that must fall.
    for (genvar b = 0; b < BCD_DIGIT_W; b++) begin : g_bit
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (~digit[b] & nxt[b]),
            .k   (digit[b] & ~nxt[b]),
            .q   (digit[b])
        );
    end

    assign is_zero = (digit == BCD_ZERO);

endmodule

// File: rtl/jk_ff.sv
// JK flip-flop storage leaf with asynchronous
// active-high reset.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/bcd_jk_down_counter.sv
// Multi-decade BCD countdown timer built from
// JK-flop digits with borrow chain and expiry pulse.
module bcd_jk_down_counter
    import bcd_jk_down_counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int WRAP   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                en,
    output logic [4*DIGITS-1:0] q,
    output logic                zero,
    output logic                borrow,
    output logic                done
);

    localparam logic [4*DIGITS-1:0] Q_ONE = 1;

    logic [DIGITS-1:0] dec;
    logic [DIGITS-1:0] dig_zero;
    logic              run;
    logic              expire;

    // Without wrap, the all-zero state stalls the chain.
    assign run = en & ~load & ((WRAP != 0) | ~zero);

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        if (i == 0) begin : g_first
            assign dec[i] = run;
        end else begin : g_rest
            assign dec[i] = dec[i-1] & dig_zero[i-1];
        end

        bcd_jk_down_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .dec_in     (dec[i]),
            .load       (load),
            .load_digit (load_val[4*i +: 4]),
            .digit      (q[4*i +: 4]),
            .is_zero    (dig_zero[i])
        );
    end

    assign zero   = &dig_zero;
    assign borrow = en & zero;
    assign expire = run & (q == Q_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= expire;
        end
    end

endmodule
